key_pulse_conditioner: RTL and testbench

//  Upstream input stage of the operand-entry path. Takes the raw push-button
//  (k), synchronises and debounces it, and emits a one-cycle press pulse (kout)
//  for the load/select FSM, plus release and long-press pulses.
//  One kout per physical press, regardless of contact bounce or hold time.

---
 rtl/key_pulse_conditioner_pkg.sv | 20 ++
 rtl/key_pulse_conditioner_sync.sv | 27 ++
 rtl/key_pulse_conditioner.sv | 132 +++++++++++++
 tb/tb_key_pulse_conditioner.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/key_pulse_conditioner_pkg.sv
// Shared definitions for the key input stage: FSM state codes, default
// timing constants and the registered output bundle.
package key_pkg;

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] PRESS_CHK = 2'd1;
  localparam logic [1:0] HELD      = 2'd2;
  localparam logic [1:0] REL_CHK   = 2'd3;

  localparam int unsigned DEF_DEBOUNCE_CYCLES = 1000000;
  localparam int unsigned DEF_LONG_CYCLES     = 50000000;

  typedef struct packed {
    logic kout;
    logic krel;
    logic klong;
    logic klevel;
  } key_out_t;

endpackage

// File: rtl/key_pulse_conditioner_sync.sv
// Two-flop synchroniser for a single asynchronous bit, with a programmable
// reset level so the output reads "inactive" while in reset.
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/key_pulse_conditioner.sv
// Debounces a raw push-button and emits one-cycle press, release and
// long-press pulses plus the debounced pressed level.
module key_pulse_conditioner
  import key_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned LONG_CYCLES     = DEF_LONG_CYCLES,
  parameter bit          ACTIVE_LOW      = 1'b0
) (
  input  logic clock,
  input  logic reset,
  input  logic k,
  output logic kout,
  output logic krel,
  output logic klong,
  output logic klevel
);

  localparam int unsigned CW = $clog2(LONG_CYCLES + 1);
  localparam logic [CW-1:0] DEB_MAX  = CW'(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] LONG_MAX = CW'(LONG_CYCLES);

  if (!(LONG_CYCLES > DEBOUNCE_CYCLES && DEBOUNCE_CYCLES >= 1)) begin : g_param_chk
    $error("key_pulse_conditioner: need LONG_CYCLES > DEBOUNCE_CYCLES >= 1");
  end

  logic          w_k_sync;
  logic          w_ks;
  logic [1:0]    r_state;
  logic [1:0]    w_state_nx;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nx;
  logic [CW-1:0] w_cnt_inc;
  logic          r_fired;
  logic          w_fired_nx;
  key_out_t      r_out;
  key_out_t      w_out_nx;

  sync_2ff #(
    .RST_VAL (ACTIVE_LOW)
  ) u_sync (
    .i_clk (clock),
    .i_rst (reset),
    .i_d   (k),
    .o_q   (w_k_sync)
  );

  assign w_ks      = w_k_sync ^ ACTIVE_LOW;
  assign w_cnt_inc = r_cnt + CW'(1);

  always_comb begin
    w_state_nx      = r_state;
    w_cnt_nx        = r_cnt;
    w_fired_nx      = r_fired;
    w_out_nx        = '0;
    w_out_nx.klevel = r_out.klevel;
    case (r_state)
      IDLE: begin
        w_out_nx.klevel = 1'b0;
        if (w_ks) begin
          w_state_nx = PRESS_CHK;
          w_cnt_nx   = CW'(1);
        end
      end
      PRESS_CHK: begin
        if (!w_ks) begin
          w_state_nx = IDLE;
          w_cnt_nx   = '0;
        end else if (w_cnt_inc >= DEB_MAX) begin
          // >= rather than == so a one-cycle debounce accepts on the first sample
          w_state_nx      = HELD;
          w_cnt_nx        = '0;
          w_out_nx.kout   = 1'b1;
          w_out_nx.klevel = 1'b1;
        end else begin
          w_cnt_nx = w_cnt_inc;
        end
      end
      HELD: begin
        if (!w_ks) begin
          w_state_nx = REL_CHK;
          w_cnt_nx   = CW'(1);
        end else if (r_cnt != LONG_MAX) begin
          w_cnt_nx = w_cnt_inc;
          if (w_cnt_inc == LONG_MAX && !r_fired) begin
            w_out_nx.klong = 1'b1;
            w_fired_nx     = 1'b1;
          end
        end
      end
      REL_CHK: begin
        if (w_ks) begin
          // bounce back into HELD: long count restarts, fired flag survives
          w_state_nx = HELD;
          w_cnt_nx   = '0;
        end else if (w_cnt_inc >= DEB_MAX) begin
          w_state_nx      = IDLE;
          w_cnt_nx        = '0;
          w_fired_nx      = 1'b0;
          w_out_nx.krel   = 1'b1;
          w_out_nx.klevel = 1'b0;
        end else begin
          w_cnt_nx = w_cnt_inc;
        end
      end
      default: begin
        w_state_nx = IDLE;
        w_cnt_nx   = '0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_fired <= 1'b0;
      r_out   <= '0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      r_fired <= w_fired_nx;
      r_out   <= w_out_nx;
    end
  end

  assign kout   = r_out.kout;
  assign krel   = r_out.krel;
  assign klong  = r_out.klong;
  assign klevel = r_out.klevel;

endmodule

// File: tb/tb_key_pulse_conditioner.sv
// Scoreboard bench: one active-high and one active-low instance with short
// debounce/long-press timings; expected output events carry absolute cycle numbers.
module tb_key_pulse_conditioner;

  localparam int K_OUT  = 0;
  localparam int K_REL  = 1;
  localparam int K_LONG = 2;
  localparam int K_RISE = 3;
  localparam int K_FALL = 4;

  typedef struct {
    int kind;
    int cyc;
  } ev_t;

  logic clock = 1'b0;
  logic rst_a, rst_b, k_a, k_b;
  logic a_kout, a_krel, a_klong, a_klevel;
  logic b_kout, b_krel, b_klong, b_klevel;
  logic a_lvl_q = 1'b0;
  logic b_lvl_q = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   fails = 0;
  ev_t  qa[$];
  ev_t  qb[$];

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  key_pulse_conditioner #(.DEBOUNCE_CYCLES(4), .LONG_CYCLES(16), .ACTIVE_LOW(1'b0)) u_dut_a (
    .clock(clock), .reset(rst_a), .k(k_a),
    .kout(a_kout), .krel(a_krel), .klong(a_klong), .klevel(a_klevel)
  );

  key_pulse_conditioner #(.DEBOUNCE_CYCLES(4), .LONG_CYCLES(16), .ACTIVE_LOW(1'b1)) u_dut_b (
    .clock(clock), .reset(rst_b), .k(k_b),
    .kout(b_kout), .krel(b_krel), .klong(b_klong), .klevel(b_klevel)
  );

  function automatic string kname(input int kind);
    case (kind)
      K_OUT:   return "kout";
      K_REL:   return "krel";
      K_LONG:  return "klong";
      K_RISE:  return "klevel_rise";
      K_FALL:  return "klevel_fall";
      default: return "none";
    endcase
  endfunction

  task automatic wait_cyc(input int n);
    while (cyc < n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic push(input int id, input int kind, input int at);
    ev_t e;
    e.kind = kind;
    e.cyc  = at;
    if (id == 0) qa.push_back(e);
    else         qb.push_back(e);
  endtask

  // Pops the next expected event for this instance and compares kind and cycle.
  task automatic see(input int id, input int kind);
    ev_t e;
    checks++;
    if ((id == 0 && qa.size() == 0) || (id == 1 && qb.size() == 0)) begin
      fails++;
      $display("FAIL dut%0d_event: got %s at cycle %0d, expected no event", id, kname(kind), cyc);
      return;
    end
    if (id == 0) e = qa.pop_front();
    else         e = qb.pop_front();
    if (e.kind != kind || e.cyc != cyc) begin
      fails++;
      $display("FAIL dut%0d_event: got %s at cycle %0d, expected %s at cycle %0d",
               id, kname(kind), cyc, kname(e.kind), e.cyc);
    end
  endtask

  task automatic chk_zero(input string name, input logic [3:0] outs);
    checks++;
    if (outs !== 4'b0000) begin
      fails++;
      $display("FAIL %s: {kout,krel,klong,klevel}=%b expected 0000", name, outs);
    end
  endtask

  always @(negedge clock) begin
    if (cyc >= 1) begin
      if (a_kout)               see(0, K_OUT);
      if (a_krel)               see(0, K_REL);
      if (a_klong)              see(0, K_LONG);
      if (a_klevel && !a_lvl_q) see(0, K_RISE);
      if (!a_klevel && a_lvl_q) see(0, K_FALL);
      a_lvl_q = a_klevel;
      if (b_kout)               see(1, K_OUT);
      if (b_krel)               see(1, K_REL);
      if (b_klong)              see(1, K_LONG);
      if (b_klevel && !b_lvl_q) see(1, K_RISE);
      if (!b_klevel && b_lvl_q) see(1, K_FALL);
      b_lvl_q = b_klevel;
    end
  end

  task automatic stim_a();
    wait_cyc(2);
    chk_zero("reset_a", {a_kout, a_krel, a_klong, a_klevel});
    wait_cyc(3);
    rst_a = 1'b0;
    // clean press, long press, release glitch, release
    wait_cyc(10);
    k_a = 1'b1;
    push(0, K_OUT, 16); push(0, K_RISE, 16); push(0, K_LONG, 32);
    wait_cyc(45); k_a = 1'b0;
    wait_cyc(47); k_a = 1'b1;
    wait_cyc(60); k_a = 1'b0;
    push(0, K_REL, 66); push(0, K_FALL, 66);
    // bounce: three high samples then one low, never long enough to accept
    wait_cyc(70);
    for (int i = 0; i < 10; i++) begin
      k_a = 1'b1;
      wait_cyc(70 + 4*i + 3);
      k_a = 1'b0;
      wait_cyc(70 + 4*i + 4);
    end
    wait_cyc(112);
    chk_zero("bounce_a", {a_kout, a_krel, a_klong, a_klevel});
    // reset while held, key stays pressed through and after reset
    wait_cyc(120);
    k_a = 1'b1;
    push(0, K_OUT, 126); push(0, K_RISE, 126);
    wait_cyc(130);
    rst_a = 1'b1;
    push(0, K_FALL, 131);
    wait_cyc(131);
    rst_a = 1'b0;
    chk_zero("reset_held_a", {a_kout, a_krel, a_klong, a_klevel});
    push(0, K_OUT, 137); push(0, K_RISE, 137); push(0, K_LONG, 153);
    wait_cyc(160);
    k_a = 1'b0;
    push(0, K_REL, 166); push(0, K_FALL, 166);
  endtask

  task automatic stim_b();
    wait_cyc(2);
    chk_zero("reset_b", {b_kout, b_krel, b_klong, b_klevel});
    wait_cyc(3);
    rst_b = 1'b0;
    wait_cyc(20);
    k_b = 1'b0;
    push(1, K_OUT, 26); push(1, K_RISE, 26); push(1, K_LONG, 42);
    wait_cyc(80);
    k_b = 1'b1;
    push(1, K_REL, 86); push(1, K_FALL, 86);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_a = 1'b1;
    rst_b = 1'b1;
    k_a   = 1'b0;
    k_b   = 1'b1;
    fork
      stim_a();
      stim_b();
    join
    wait_cyc(200);
    checks++;
    if (qa.size() != 0) begin
      fails++;
      $display("FAIL dut0_pending: %0d expected events never seen, first %s at cycle %0d",
               qa.size(), kname(qa[0].kind), qa[0].cyc);
    end
    checks++;
    if (qb.size() != 0) begin
      fails++;
      $display("FAIL dut1_pending: %0d expected events never seen, first %s at cycle %0d",
               qb.size(), kname(qb[0].kind), qb[0].cyc);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
